// File: rtl/rate_block_absorber.sv
// rate_block_absorber: packs 64-bit message words into Keccak rate blocks.
// Two block buffers alternate roles, so one can fill while the other waits
// for the permutation core. The final word of a message sets the 0x80 pad bit
// in the top byte of the last lane. A released buffer is zeroed so that lanes
// after the last written word of a short message read as zero.
module rate_block_absorber #(
  parameter int RATE_LANES = 21
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [63:0]             msgn,
  input  logic                    msgn_val,
  input  logic                    lastmsgn_val,
  output logic                    in_ready,
  output logic [64*RATE_LANES-1:0] blk_data,
  output logic                    blk_val,
  output logic                    blk_last,
  input  logic                    blk_ready,
  output logic                    err_ovf
);

  localparam int BLK_W  = 64 * RATE_LANES;
  localparam int LIDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  // Most significant bit of the last lane: the 0x80 pad bit.
  localparam int PAD_BIT = BLK_W - 1;
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(RATE_LANES - 1);

  logic [BLK_W-1:0]  buf_q [2];
  logic [BLK_W-1:0]  buf_d [2];
  logic [1:0]        full_q, full_d;
  logic [1:0]        last_q, last_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [LIDX_W-1:0] lane_idx_q, lane_idx_d;
  logic              err_ovf_q, err_ovf_d;

  logic [63:0]       msgn_swap;
  logic [LIDX_W+5:0] lane_base;
  logic              accept;
  logic              complete;
  logic              xfer;

  // First message byte (msgn[63:56]) becomes the least significant lane byte.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bswap
    assign msgn_swap[8*gi +: 8] = msgn[63-8*gi -: 8];
  end

  assign lane_base = {lane_idx_q, 6'd0};

  // Acceptance and transfer depend only on registered state, so a buffer
  // freed by a transfer this cycle cannot take a word in the same cycle.
  assign accept   = msgn_val && !full_q[wr_sel_q];
  assign complete = accept && ((lane_idx_q == LAST_LANE) || lastmsgn_val);
  assign xfer     = full_q[rd_sel_q] && blk_ready;

  // Next state of both buffers: zero on transfer, lane write and pad on accept.
  // Accept targets an empty buffer and transfer a full one, so they never hit
  // the same buffer in one cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      buf_d[b[0]]  = buf_q[b[0]];
      full_d[b[0]] = full_q[b[0]];
      last_d[b[0]] = last_q[b[0]];
      if (xfer && (rd_sel_q == b[0])) begin
        buf_d[b[0]]  = '0;
        full_d[b[0]] = 1'b0;
        last_d[b[0]] = 1'b0;
      end
      if (accept && (wr_sel_q == b[0])) begin
        buf_d[b[0]][lane_base +: 64] = msgn_swap;
        if (lastmsgn_val) begin
          buf_d[b[0]][PAD_BIT] = 1'b1;
        end
        if (complete) begin
          full_d[b[0]] = 1'b1;
          last_d[b[0]] = lastmsgn_val;
        end
      end
    end
  end

  // Next state of the buffer selectors, lane counter and sticky overflow flag.
  always_comb begin
    wr_sel_d   = wr_sel_q ^ complete;
    rd_sel_d   = rd_sel_q ^ xfer;
    lane_idx_d = lane_idx_q;
    if (complete) begin
      lane_idx_d = '0;
    end else if (accept) begin
      lane_idx_d = lane_idx_q + 1'b1;
    end
    err_ovf_d = err_ovf_q | (msgn_val && full_q[wr_sel_q]);
  end

  // State registers; reset discards any partial or pending block at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      full_q     <= '0;
      last_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      lane_idx_q <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      full_q     <= full_d;
      last_q     <= last_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      lane_idx_q <= lane_idx_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  assign in_ready = !full_q[wr_sel_q];
  assign blk_val  = full_q[rd_sel_q];
  assign blk_last = last_q[rd_sel_q];
  assign blk_data = buf_q[rd_sel_q];
  assign err_ovf  = err_ovf_q;

endmodule
